// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: decoder bundle bit positions, opcodes, ALUOp codes, widths.
package mips_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 10;
  localparam int DATA_W    = 32;
  localparam int FUNCT_W   = 6;

  // Decoder bundle {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jal,ALUOp[1:0]}
  localparam int CTRL_REG_DST    = 9;
  localparam int CTRL_ALU_SRC    = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JAL        = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // An instruction reads rt as a source when it is R-type, a store or a branch.
  function automatic logic reads_rt(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REG_DST] | ctrl[CTRL_MEM_WRITE] | ctrl[CTRL_BRANCH];
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: flags an ID instruction that consumes the destination of a load sitting in EX.
module hazard_unit
  import mips_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 id_valid,
  input  logic                 id_reads_rt,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 suppress,
  output logic                 hazard_stall
);

  logic load_in_ex;
  logic rs_match;
  logic rt_match;

  // r0 is never a real dependency, so a load targeting it cannot stall.
  assign load_in_ex   = ex_valid & ex_mem_read & (ex_rt != '0);
  assign rs_match     = (id_rs == ex_rt);
  assign rt_match     = (id_rt == ex_rt) & id_reads_rt;
  assign hazard_stall = ~suppress & load_in_ex & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, EX back-pressure and optional load-use stall.
// Define LOAD_USE_DETECT_EN to build the load-use hazard unit; otherwise hazard_stall is tied low.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [DATA_W-1:0]    id_rs_data,
  input  logic [DATA_W-1:0]    id_rt_data,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [DATA_W-1:0]    id_pc_plus4,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [FUNCT_W-1:0]   id_funct,
  input  logic                 flush,
  input  logic                 ex_stall,
  output logic                 ex_valid,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [DATA_W-1:0]    ex_rs_data,
  output logic [DATA_W-1:0]    ex_rt_data,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [DATA_W-1:0]    ex_pc_plus4,
  output logic [REG_IDX_W-1:0] ex_rs,
  output logic [REG_IDX_W-1:0] ex_rt,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [FUNCT_W-1:0]   ex_funct,
  output logic                 hazard_stall
);

  // Handshake: id_valid qualifies the ID bundle; the stage accepts it on any edge where
  // reset, flush, ex_stall and hazard_stall are all low. ex_valid qualifies the EX bundle.

`ifdef LOAD_USE_DETECT_EN
  hazard_unit u_hazard_unit (
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl[CTRL_MEM_READ]),
    .ex_rt        (ex_rt),
    .id_valid     (id_valid),
    .id_reads_rt  (reads_rt(id_ctrl)),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .suppress     (flush | reset),
    .hazard_stall (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc_plus4 <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!ex_stall) begin
      if (hazard_stall) begin
        // Bubble: only control is cleared, which also drops MemRead and ends the stall.
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= id_valid ? id_ctrl : '0;
        ex_rs_data  <= id_rs_data;
        ex_rt_data  <= id_rt_data;
        ex_imm      <= id_imm;
        ex_pc_plus4 <= id_pc_plus4;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_funct    <= id_funct;
      end
    end
  end

endmodule
